// File: rtl/riscv_halt_monitor.sv
// End-of-program monitor for the single-cycle RISC-V core: detects ECALL/EBREAK,
// jump-to-self loops and watchdog expiry, freezes the core, drains, then raises finish_flag.
module riscv_halt_monitor #(
    parameter int XLEN         = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int LOOP_LIMIT   = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int WDT_CYCLES   = 100000
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [XLEN-1:0]      pc,
    input  logic [31:0]          instr,
    output logic                 stall_core,
    output logic                 finish_flag,
    output logic [1:0]           halt_cause,
    output logic [XLEN-1:0]      halt_pc,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    localparam int LOOP_W  = $clog2(LOOP_LIMIT + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam bit WDT_EN  = (WDT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] WDT_LAST =
        (WDT_CYCLES == 0) ? '0 : CNT_WIDTH'(WDT_CYCLES - 1);

    localparam logic [31:0] ENC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] ENC_EBREAK = 32'h0010_0073;

    localparam logic [1:0] CAUSE_SYS  = 2'b01;
    localparam logic [1:0] CAUSE_LOOP = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]    prev_pc;
    logic               prev_vld;
    logic [LOOP_W-1:0]  loop_cnt;
    logic [LOOP_W-1:0]  loop_inc;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_inc;

    logic in_run;
    logic t_sys;
    logic t_loop;
    logic t_wdt;
    logic repeat_hit;
    logic trigger;
    logic [1:0] cause_win;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Trigger evaluation; only meaningful while running
    always_comb begin
        in_run     = (state == ST_RUN);
        repeat_hit = instr_valid && prev_vld && (pc == prev_pc);
        loop_inc   = loop_cnt + LOOP_W'(1);
        drain_inc  = drain_cnt + DRAIN_W'(1);
        t_sys      = instr_valid && ((instr == ENC_ECALL) || (instr == ENC_EBREAK));
        t_loop     = repeat_hit && (loop_inc == LOOP_W'(LOOP_LIMIT));
        t_wdt      = WDT_EN && (cycle_count == WDT_LAST);
        trigger    = in_run && (t_sys || t_loop || t_wdt);
        if (t_sys)       cause_win = CAUSE_SYS;
        else if (t_loop) cause_win = CAUSE_LOOP;
        else             cause_win = CAUSE_WDT;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (trigger) state_nxt = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_inc == DRAIN_W'(DRAIN_CYCLES)) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        stall_core  = (state != ST_RUN);
        finish_flag = (state == ST_DONE);
    end

    // Counters, loop tracking and halt capture; everything clears on reset
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cycle_count   <= '0;
            instret_count <= '0;
            prev_pc       <= '0;
            prev_vld      <= 1'b0;
            loop_cnt      <= '0;
            drain_cnt     <= '0;
            halt_cause    <= 2'b00;
            halt_pc       <= '0;
        end else begin
            if (state != ST_DONE) cycle_count <= sat_inc(cycle_count);
            if (in_run) begin
                drain_cnt <= '0;
                if (instr_valid) begin
                    instret_count <= sat_inc(instret_count);
                    prev_pc       <= pc;
                    prev_vld      <= 1'b1;
                    loop_cnt      <= repeat_hit ? loop_inc : '0;
                end
                if (trigger) begin
                    halt_cause <= cause_win;
                    halt_pc    <= pc;
                end
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_inc;
            end
        end
    end

endmodule
